// File: rtl/jb_adc_iq_capture.sv
// jb_adc_iq_capture: snapshot capture of one decimated ADC IQ lane into the
// debug buffer RAM (port B), packing two 32-bit samples per 64-bit word.
//
// Optional feature macro: JB_ADC_IQ_CAP_FS_CNT_EN (full-scale sample counter).
//
// Ports:
//   clk_3x, rst_3x     capture clock, synchronous active-high reset
//   s_iq_tdata/tvalid  N_LANES lanes of {Q,I} samples with per-lane valid
//   frm_mrkr, syn_5ms  trigger markers (rising edge used)
//   cfg_*              lane select, trigger mode, length, start/abort pulses
//   mem_*              debug buffer port-B write (we, word addr, data)
//   sts_*              busy, sticky done, word count, full-scale count
module jb_adc_iq_capture #(
   parameter int N_ANTS_SEL = 2,
   parameter int N_ANTENNAS = 4,
   parameter int ADDR_WIDTH = 15,
   parameter int N_LANES    = N_ANTS_SEL * N_ANTENNAS,
   parameter int SEL_W      = $clog2(N_LANES)
) (
   input  logic                    clk_3x,
   input  logic                    rst_3x,
   input  logic [N_LANES*32-1:0]   s_iq_tdata,
   input  logic [N_LANES-1:0]      s_iq_tvalid,
   input  logic                    frm_mrkr,
   input  logic                    syn_5ms,
   input  logic [SEL_W-1:0]        cfg_ant_sel,
   input  logic [1:0]              cfg_trig_mode,
   input  logic [ADDR_WIDTH:0]     cfg_num_words,
   input  logic                    cfg_start,
   input  logic                    cfg_abort,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [63:0]             mem_wdata,
   output logic                    sts_busy,
   output logic                    sts_done,
   output logic [ADDR_WIDTH:0]     sts_words,
   output logic [15:0]             sts_fs_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAP,
      S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t r_state;
   state_t w_state_nxt;

   logic [SEL_W-1:0]    r_sel;
   logic [1:0]          r_mode;
   logic [ADDR_WIDTH:0] r_len;

   logic [31:0]         r_lane_data;
   logic                r_lane_vld;
   logic                r_frm_d;
   logic                r_syn_d;
   logic                r_frm_rise;
   logic                r_syn_rise;

   logic                r_half;
   logic [31:0]         r_pack_lo;
   logic [ADDR_WIDTH:0] r_pk_cnt;
   logic                r_wvld;
   logic [63:0]         r_wword;

   logic [31:0]         w_lanes [N_LANES];
   logic [SEL_W-1:0]    w_sel;
   logic                w_start;
   logic [ADDR_WIDTH:0] w_len_clamp;
   logic                w_imm;
   logic                w_trig;
   logic                w_take;
   logic                w_last_wr;

   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
         w_lanes[k] = s_iq_tdata[k*32 +: 32];
      end
   end

   assign w_start = cfg_start & ~cfg_abort &
                    ((r_state == S_IDLE) | (r_state == S_DONE));

   assign w_len_clamp = (cfg_num_words > MAX_LEN) ? MAX_LEN : cfg_num_words;
   assign w_imm       = (cfg_trig_mode == 2'd0) | (cfg_trig_mode == 2'd3);

   // Steer the mux to the new lane in the start cycle so the very first
   // registered sample after arming already comes from the selected lane.
   assign w_sel = w_start ? cfg_ant_sel : r_sel;

   // Trigger pulse and sample share the input register stage, so the
   // sample sitting in r_lane_data is the one from the marker edge cycle.
   assign w_trig = ((r_mode == 2'd1) & r_frm_rise) |
                   ((r_mode == 2'd2) & r_syn_rise);

   // Stop sampling once the last word is packed; writes still in flight
   // finish on their own.
   assign w_take = r_lane_vld & ~cfg_abort & (r_pk_cnt < r_len) &
                   ((r_state == S_CAP) | ((r_state == S_WAIT) & w_trig));

   assign w_last_wr = (r_state == S_CAP) & mem_we &
                      (sts_words == (r_len - ONE_W));

   assign sts_busy = (r_state == S_WAIT) | (r_state == S_CAP);

   always_ff @(posedge clk_3x) begin
      if (rst_3x) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (cfg_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (cfg_start) begin
                  if (w_len_clamp == '0) begin
                     w_state_nxt = S_DONE;
                  end else if (w_imm) begin
                     w_state_nxt = S_CAP;
                  end else begin
                     w_state_nxt = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (w_trig) begin
                  w_state_nxt = S_CAP;
               end
            end
            S_CAP: begin
               if (w_last_wr) begin
                  w_state_nxt = S_DONE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_3x) begin
      if (rst_3x) begin
         r_sel       <= '0;
         r_mode      <= '0;
         r_len       <= '0;
         r_lane_data <= '0;
         r_lane_vld  <= 1'b0;
         r_frm_d     <= 1'b0;
         r_syn_d     <= 1'b0;
         r_frm_rise  <= 1'b0;
         r_syn_rise  <= 1'b0;
         r_half      <= 1'b0;
         r_pack_lo   <= '0;
         r_pk_cnt    <= '0;
         r_wvld      <= 1'b0;
         r_wword     <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         sts_done    <= 1'b0;
         sts_words   <= '0;
      end else begin
         r_frm_d     <= frm_mrkr;
         r_syn_d     <= syn_5ms;
         r_frm_rise  <= frm_mrkr & ~r_frm_d;
         r_syn_rise  <= syn_5ms & ~r_syn_d;
         r_lane_data <= w_lanes[w_sel];
         r_lane_vld  <= s_iq_tvalid[w_sel];

         r_wvld <= 1'b0;
         mem_we <= r_wvld & ~cfg_abort;
         if (r_wvld) begin
            mem_wdata <= r_wword;
         end
         if (mem_we) begin
            mem_addr  <= mem_addr + 1'b1;
            sts_words <= sts_words + ONE_W;
         end

         if (w_last_wr & ~cfg_abort) begin
            sts_done <= 1'b1;
         end

         if (w_start) begin
            r_sel     <= cfg_ant_sel;
            r_mode    <= cfg_trig_mode;
            r_len     <= w_len_clamp;
            r_half    <= 1'b0;
            r_pack_lo <= '0;
            r_pk_cnt  <= '0;
            mem_addr  <= '0;
            sts_words <= '0;
            sts_done  <= (w_len_clamp == '0);
         end else if (cfg_abort) begin
            r_half    <= 1'b0;
         end else if (w_take) begin
            if (!r_half) begin
               r_pack_lo <= r_lane_data;
               r_half    <= 1'b1;
            end else begin
               r_wword  <= {r_lane_data, r_pack_lo};
               r_wvld   <= 1'b1;
               r_half   <= 1'b0;
               r_pk_cnt <= r_pk_cnt + ONE_W;
            end
         end
      end
   end

`ifdef JB_ADC_IQ_CAP_FS_CNT_EN
   logic [15:0] r_fs_cnt;
   logic [15:0] w_i;
   logic [15:0] w_q;
   logic        w_fs;

   assign w_i  = r_lane_data[15:0];
   assign w_q  = r_lane_data[31:16];
   assign w_fs = (w_i == 16'h7FFF) | (w_i == 16'h8000) |
                 (w_q == 16'h7FFF) | (w_q == 16'h8000);

   always_ff @(posedge clk_3x) begin
      if (rst_3x) begin
         r_fs_cnt <= '0;
      end else if (w_start) begin
         r_fs_cnt <= '0;
      end else if (w_take & w_fs & (r_fs_cnt != 16'hFFFF)) begin
         r_fs_cnt <= r_fs_cnt + 16'd1;
      end
   end

   assign sts_fs_cnt = r_fs_cnt;
`else
   assign sts_fs_cnt = '0;
`endif

endmodule
